// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner: FSM state encoding,
// key-index width and the lowest-zero priority encoder used to pick the row.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DEBOUNCE,
    S_HELD
  } state_e;

  // Width of the binary key index for a rows x cols matrix.
  function automatic int kw(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Index of the lowest 0 bit; an all-ones input yields 0 (callers gate on "any low").
  function automatic logic [2:0] lowest_zero(input logic [7:0] v);
    lowest_zero = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) lowest_zero = 3'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan-tick strobe: one clk high every CLK_DIV clocks after reset.
// Shared by the scanned peripherals; reset is synchronous, active-low.
module keypad_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] r_div;

  assign o_tick = (r_div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset)      r_div <= '0;
    else if (o_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

endmodule

// File: rtl/keypad_matrix_scan.sv
// ROWS x COLS keypad scanner: tick-paced column scan, row synchroniser, debounce,
// press/release pulses and held level. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CLK_DIV      = 50,
  parameter int DEBOUNCE     = 8,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 50,
  localparam int KW          = kw(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_value,
  output logic            key_valid,
  output logic            key_release,
  output logic            key_held
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(DEBOUNCE + 1);

  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || CLK_DIV < 2 || DEBOUNCE < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_matrix_scan: parameter out of range");
  end

  function automatic logic [COLS-1:0] col_drive(input logic [CW-1:0] c);
    col_drive    = '1;
    col_drive[c] = 1'b0;
  endfunction

  logic            w_tick;
  logic [ROWS-1:0] r_sync1, r_sync2;
  logic [7:0]      w_rs_pad;
  logic            w_any_low;

  state_e          r_state,       r_state_n;
  logic [CW-1:0]   r_c,           r_c_n;
  logic [COLS-1:0] r_col,         r_col_n;
  logic [CW-1:0]   r_cap_col,     r_cap_col_n;
  logic [RW-1:0]   r_cap_row,     r_cap_row_n;
  logic [DW-1:0]   r_cnt,         r_cnt_n;
  logic [KW-1:0]   r_key_value,   r_key_value_n;
  logic            r_key_valid,   r_key_valid_n;
  logic            r_key_release, r_key_release_n;
  logic            r_key_held,    r_key_held_n;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW     = $clog2(RPT_MAX + 1);
  logic [RPW-1:0] r_rpt,       r_rpt_n;
  logic           r_rpt_first, r_rpt_first_n;
`endif

  keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .o_tick (w_tick)
  );

  // Idle rows float high through the pull-ups, so the synchroniser resets to 1s.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= row;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_rs_pad             = '1;
    w_rs_pad[ROWS-1:0]   = r_sync2;
    w_any_low            = (r_sync2 != '1);
  end

  // NOTE: state-holding registers use non-blocking assignments so every flop
  // samples pre-edge values; the combinational block below uses blocking ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_c           <= '0;
      r_col         <= '0;
      r_cap_col     <= '0;
      r_cap_row     <= '0;
      r_cnt         <= '0;
      r_key_value   <= '0;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
      r_key_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rpt         <= '0;
      r_rpt_first   <= 1'b1;
`endif
    end else begin
      r_state       <= r_state_n;
      r_c           <= r_c_n;
      r_col         <= r_col_n;
      r_cap_col     <= r_cap_col_n;
      r_cap_row     <= r_cap_row_n;
      r_cnt         <= r_cnt_n;
      r_key_value   <= r_key_value_n;
      r_key_valid   <= r_key_valid_n;
      r_key_release <= r_key_release_n;
      r_key_held    <= r_key_held_n;
`ifdef KEYPAD_REPEAT_EN
      r_rpt         <= r_rpt_n;
      r_rpt_first   <= r_rpt_first_n;
`endif
    end
  end

  always_comb begin
    // NOTE: every next-value gets a default before the case so no path can
    // leave a signal unassigned and infer a latch.
    r_state_n       = r_state;
    r_c_n           = r_c;
    r_col_n         = r_col;
    r_cap_col_n     = r_cap_col;
    r_cap_row_n     = r_cap_row;
    r_cnt_n         = r_cnt;
    r_key_value_n   = r_key_value;
    r_key_valid_n   = 1'b0;
    r_key_release_n = 1'b0;
    r_key_held_n    = r_key_held;
`ifdef KEYPAD_REPEAT_EN
    r_rpt_n         = r_rpt;
    r_rpt_first_n   = r_rpt_first;
`endif

    unique case (r_state)
      S_IDLE: begin
        r_col_n = '0;
        if (w_tick && w_any_low) begin
          r_state_n = S_SCAN;
          r_c_n     = '0;
          r_col_n   = col_drive('0);
        end
      end

      S_SCAN: if (w_tick) begin
        if (w_any_low) begin
          r_cap_col_n = r_c;
          r_cap_row_n = RW'(lowest_zero(w_rs_pad));
          r_cnt_n     = DW'(1);
          r_state_n   = S_DEBOUNCE;
        end else if (r_c == CW'(COLS - 1)) begin
          r_state_n = S_IDLE;
          r_col_n   = '0;
        end else begin
          r_c_n   = r_c + 1'b1;
          r_col_n = col_drive(r_c_n);
        end
      end

      S_DEBOUNCE: if (w_tick) begin
        if (!r_sync2[r_cap_row]) begin
          // The capture tick already counted one low sample.
          if (int'(r_cnt) + 1 >= DEBOUNCE) begin
            r_key_value_n = KW'(int'(r_cap_col) * ROWS + int'(r_cap_row));
            r_key_valid_n = 1'b1;
            r_key_held_n  = 1'b1;
            r_cnt_n       = '0;
            r_state_n     = S_HELD;
`ifdef KEYPAD_REPEAT_EN
            r_rpt_n       = '0;
            r_rpt_first_n = 1'b1;
`endif
          end else begin
            r_cnt_n = r_cnt + 1'b1;
          end
        end else begin
          r_state_n = S_IDLE;
          r_col_n   = '0;
        end
      end

      S_HELD: if (w_tick) begin
        if (r_sync2[r_cap_row] && (int'(r_cnt) + 1 >= DEBOUNCE)) begin
          r_key_release_n = 1'b1;
          r_key_held_n    = 1'b0;
          r_cnt_n         = '0;
          r_state_n       = S_IDLE;
          r_col_n         = '0;
`ifdef KEYPAD_REPEAT_EN
          r_rpt_n         = '0;
          r_rpt_first_n   = 1'b1;
`endif
        end else begin
          r_cnt_n = r_sync2[r_cap_row] ? r_cnt + 1'b1 : '0;
`ifdef KEYPAD_REPEAT_EN
          if (int'(r_rpt) + 1 >= (r_rpt_first ? REPEAT_DELAY : REPEAT_RATE)) begin
            r_key_valid_n = 1'b1;
            r_rpt_n       = '0;
            r_rpt_first_n = 1'b0;
          end else begin
            r_rpt_n = r_rpt + 1'b1;
          end
`endif
        end
      end

      default: r_state_n = S_IDLE;
    endcase
  end

  assign col         = r_col;
  assign key_value   = r_key_value;
  assign key_valid   = r_key_valid;
  assign key_release = r_key_release;
  assign key_held    = r_key_held;

endmodule
